// File: rtl/gerador_imediato_pipeline_if.sv
// Handshake bundle for the pipelined immediate generator: instruction in,
// decoded immediate/format/illegal flag out, plus flush.
interface gerador_imediato_pipeline_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instrucao;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imediato;
  logic [2:0]      formato;
  logic            ilegal;

  modport master (
    output in_valid, instrucao, flush, out_ready,
    input  in_ready, out_valid, imediato, formato, ilegal
  );

  modport slave (
    input  in_valid, instrucao, flush, out_ready,
    output in_ready, out_valid, imediato, formato, ilegal
  );
endinterface

// File: rtl/gerador_imediato_pipeline.sv
// Registered RISC-V immediate generator: combinational decode in front of
// STAGES valid/ready slots with back-pressure and synchronous flush.
module gerador_imediato_pipeline #(
  parameter int XLEN     = 32,
  parameter int STAGES   = 1,
  parameter int ENABLE_U = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  gerador_imediato_pipeline_if.slave  bus
);

  typedef struct packed {
    logic signed [XLEN-1:0] imm;
    logic [2:0]             fmt;
    logic                   ileg;
  } payload_t;

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    logic [63:0] w;
    w = {{32{v[31]}}, v};
    return w[XLEN-1:0];
  endfunction

  // Every immediate is first assembled as a sign-correct 32-bit value, then widened.
  function automatic payload_t decode(input logic [31:0] i);
    payload_t           p;
    logic signed [31:0] v;
    v      = '0;
    p.fmt  = 3'd7;
    p.ileg = 1'b1;
    case (i[6:0])
      7'b0110011: begin
        p.fmt  = 3'd0;
        p.ileg = 1'b0;
      end
      7'b0000011, 7'b1100111: begin
        v      = {{20{i[31]}}, i[31:20]};
        p.fmt  = 3'd1;
        p.ileg = 1'b0;
      end
      7'b0010011: begin
        p.ileg = 1'b0;
        if (i[13:12] == 2'b01) begin
          v     = (XLEN == 64) ? {26'b0, i[25:20]} : {27'b0, i[24:20]};
          p.fmt = 3'd6;
        end else begin
          v     = {{20{i[31]}}, i[31:20]};
          p.fmt = 3'd1;
        end
      end
      7'b0100011: begin
        v      = {{20{i[31]}}, i[31:25], i[11:7]};
        p.fmt  = 3'd2;
        p.ileg = 1'b0;
      end
      7'b1100011: begin
        v      = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        p.fmt  = 3'd3;
        p.ileg = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        if (ENABLE_U != 0) begin
          v      = {i[31:12], 12'b0};
          p.fmt  = 3'd4;
          p.ileg = 1'b0;
        end
      end
      7'b1101111: begin
        v      = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        p.fmt  = 3'd5;
        p.ileg = 1'b0;
      end
      default: ;
    endcase
    p.imm = sext32(v);
    return p;
  endfunction

  logic     vld_p0_q, vld_p0_d;
  payload_t dat_p0_q, dat_p0_d;
  logic     ld_p0;
  logic     take_p0;
  logic     vld_last;
  payload_t dat_last;

  // Stage 0: decode and capture
  always_comb begin
    dat_p0_d = decode(bus.instrucao);
    ld_p0    = !vld_p0_q || take_p0;
    vld_p0_d = vld_p0_q;
    if (bus.flush)  vld_p0_d = 1'b0;
    else if (ld_p0) vld_p0_d = bus.in_valid;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_p0_q <= 1'b0;
    else       vld_p0_q <= vld_p0_d;
  end

  always_ff @(posedge clock) begin
    if (ld_p0 && bus.in_valid) dat_p0_q <= dat_p0_d;
  end

  generate
    if (STAGES == 2) begin : g_s2
      logic     vld_p1_q, vld_p1_d;
      payload_t dat_p1_q, dat_p1_d;
      logic     ld_p1;

      // Stage 1: pure re-register of stage 0
      always_comb begin
        ld_p1    = !vld_p1_q || bus.out_ready;
        dat_p1_d = dat_p0_q;
        vld_p1_d = vld_p1_q;
        if (bus.flush)  vld_p1_d = 1'b0;
        else if (ld_p1) vld_p1_d = vld_p0_q;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) vld_p1_q <= 1'b0;
        else       vld_p1_q <= vld_p1_d;
      end

      always_ff @(posedge clock) begin
        if (ld_p1 && vld_p0_q) dat_p1_q <= dat_p1_d;
      end

      assign take_p0  = ld_p1;
      assign vld_last = vld_p1_q;
      assign dat_last = dat_p1_q;
    end else begin : g_s1
      assign take_p0  = bus.out_ready;
      assign vld_last = vld_p0_q;
      assign dat_last = dat_p0_q;
    end
  endgenerate

  // Payload is gated by valid so reset and empty slots read as zero, never stale.
  assign bus.in_ready  = ld_p0;
  assign bus.out_valid = vld_last;
  assign bus.imediato  = vld_last ? dat_last.imm  : '0;
  assign bus.formato   = vld_last ? dat_last.fmt  : 3'd0;
  assign bus.ilegal    = vld_last ? dat_last.ileg : 1'b0;

endmodule

// File: tb/tb_gerador_imediato_pipeline.sv
// Drives four configurations of the immediate generator with one shared
// stimulus stream and compares every cycle against a slot-level reference.
module tb_gerador_imediato_pipeline;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid_t;
  logic [31:0] instr_t;
  logic        flush_t;
  logic        out_ready_t;

  int checks   = 0;
  int failures = 0;

  int stg[4] = '{1, 2, 1, 1};
  int xl[4]  = '{32, 32, 64, 32};
  bit eu[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};

  bit          mv[4][2];
  logic [63:0] mimm[4][2];
  logic [2:0]  mfmt[4][2];
  logic        mil[4][2];

  always #5 clock = ~clock;

  gerador_imediato_pipeline_if #(.XLEN(32)) b0();
  gerador_imediato_pipeline_if #(.XLEN(32)) b1();
  gerador_imediato_pipeline_if #(.XLEN(64)) b2();
  gerador_imediato_pipeline_if #(.XLEN(32)) b3();

  assign b0.in_valid = in_valid_t;  assign b0.instrucao = instr_t;
  assign b0.flush    = flush_t;     assign b0.out_ready = out_ready_t;
  assign b1.in_valid = in_valid_t;  assign b1.instrucao = instr_t;
  assign b1.flush    = flush_t;     assign b1.out_ready = out_ready_t;
  assign b2.in_valid = in_valid_t;  assign b2.instrucao = instr_t;
  assign b2.flush    = flush_t;     assign b2.out_ready = out_ready_t;
  assign b3.in_valid = in_valid_t;  assign b3.instrucao = instr_t;
  assign b3.flush    = flush_t;     assign b3.out_ready = out_ready_t;

  gerador_imediato_pipeline #(.XLEN(32), .STAGES(1), .ENABLE_U(1)) u0 (.clock(clock), .reset(reset), .bus(b0));
  gerador_imediato_pipeline #(.XLEN(32), .STAGES(2), .ENABLE_U(1)) u1 (.clock(clock), .reset(reset), .bus(b1));
  gerador_imediato_pipeline #(.XLEN(64), .STAGES(1), .ENABLE_U(1)) u2 (.clock(clock), .reset(reset), .bus(b2));
  gerador_imediato_pipeline #(.XLEN(32), .STAGES(1), .ENABLE_U(0)) u3 (.clock(clock), .reset(reset), .bus(b3));

  // Reference decode written directly from the immediate bit layouts.
  task automatic ref_dec(input logic [31:0] i, input int x, input bit u,
                         output logic [63:0] imm, output logic [2:0] f, output logic il);
    longint v;
    v = 0; f = 3'd7; il = 1'b1;
    case (i[6:0])
      7'b0110011: begin f = 3'd0; il = 1'b0; end
      7'b0000011, 7'b1100111: begin v = longint'($signed(i[31:20])); f = 3'd1; il = 1'b0; end
      7'b0010011: begin
        il = 1'b0;
        if (i[14:12] == 3'b001 || i[14:12] == 3'b101) begin
          v = (x == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
          f = 3'd6;
        end else begin
          v = longint'($signed(i[31:20])); f = 3'd1;
        end
      end
      7'b0100011: begin v = longint'($signed({i[31:25], i[11:7]})); f = 3'd2; il = 1'b0; end
      7'b1100011: begin v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); f = 3'd3; il = 1'b0; end
      7'b0110111, 7'b0010111: if (u) begin v = longint'($signed({i[31:12], 12'h000})); f = 3'd4; il = 1'b0; end
      7'b1101111: begin v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); f = 3'd5; il = 1'b0; end
      default: ;
    endcase
    imm = (x == 32) ? {32'b0, v[31:0]} : v;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic loads(input int d, output bit [2:0] ld);
    ld = '0;
    for (int k = stg[d] - 1; k >= 0; k--)
      ld[k] = !mv[d][k] || ((k == stg[d] - 1) ? out_ready_t : ld[k+1]);
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 4; d++) begin
      logic ov, il, ir;
      logic [63:0] im;
      logic [2:0] f;
      bit [2:0] ld;
      int l;
      case (d)
        0: begin ov = b0.out_valid; im = {32'b0, b0.imediato}; f = b0.formato; il = b0.ilegal; ir = b0.in_ready; end
        1: begin ov = b1.out_valid; im = {32'b0, b1.imediato}; f = b1.formato; il = b1.ilegal; ir = b1.in_ready; end
        2: begin ov = b2.out_valid; im = b2.imediato;          f = b2.formato; il = b2.ilegal; ir = b2.in_ready; end
        default: begin ov = b3.out_valid; im = {32'b0, b3.imediato}; f = b3.formato; il = b3.ilegal; ir = b3.in_ready; end
      endcase
      l = stg[d] - 1;
      loads(d, ld);
      chk($sformatf("%s.d%0d.out_valid", tag, d), 64'(ov), 64'(mv[d][l]));
      chk($sformatf("%s.d%0d.imediato", tag, d), im, mv[d][l] ? mimm[d][l] : 64'd0);
      chk($sformatf("%s.d%0d.formato", tag, d), 64'(f), mv[d][l] ? 64'(mfmt[d][l]) : 64'd0);
      chk($sformatf("%s.d%0d.ilegal", tag, d), 64'(il), mv[d][l] ? 64'(mil[d][l]) : 64'd0);
      chk($sformatf("%s.d%0d.in_ready", tag, d), 64'(ir), 64'(ld[0]));
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 4; d++) begin
      bit [2:0] ld;
      loads(d, ld);
      if (flush_t) begin
        mv[d][0] = 1'b0; mv[d][1] = 1'b0;
      end else begin
        for (int k = stg[d] - 1; k >= 1; k--) if (ld[k]) begin
          mv[d][k] = mv[d][k-1]; mimm[d][k] = mimm[d][k-1];
          mfmt[d][k] = mfmt[d][k-1]; mil[d][k] = mil[d][k-1];
        end
        if (ld[0]) begin
          mv[d][0] = in_valid_t;
          if (in_valid_t) ref_dec(instr_t, xl[d], eu[d], mimm[d][0], mfmt[d][0], mil[d][0]);
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 4; d++) begin
      mv[d][0] = 1'b0; mv[d][1] = 1'b0;
    end
  endtask

  task automatic drive_and_check(input string tag, input logic v, input logic [31:0] ins,
                                 input logic fl, input logic ordy);
    in_valid_t = v; instr_t = ins; flush_t = fl; out_ready_t = ordy;
    #1;
    check_all(tag);
    model_step();
  endtask

  task automatic cycle(input string tag, input logic v, input logic [31:0] ins,
                       input logic fl, input logic ordy);
    drive_and_check(tag, v, ins, fl, ordy);
    @(negedge clock);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: r[6:0] = 7'b0110011;
      1: r[6:0] = 7'b0000011;
      2: r[6:0] = 7'b1100111;
      3, 4: r[6:0] = 7'b0010011;
      5: r[6:0] = 7'b0100011;
      6: r[6:0] = 7'b1100011;
      7: r[6:0] = 7'b0110111;
      8: r[6:0] = 7'b0010111;
      9: r[6:0] = 7'b1101111;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    reset = 1'b1; in_valid_t = 1'b0; instr_t = '0; flush_t = 1'b0; out_ready_t = 1'b1;
    model_clear();
    #2;
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;

    // Directed vectors with the consumer always ready.
    cycle("v_i",    1'b1, 32'hFFF00093, 1'b0, 1'b1);
    chk("v_i.direct", {32'b0, b0.imediato}, 64'h0000_0000_FFFF_FFFF);
    cycle("v_s",    1'b1, 32'hFE112E23, 1'b0, 1'b1);
    chk("v_s.direct", {32'b0, b0.imediato}, 64'h0000_0000_FFFF_FFFC);
    cycle("v_b",    1'b1, 32'hFE000CE3, 1'b0, 1'b1);
    chk("v_b.direct", {32'b0, b0.imediato}, 64'h0000_0000_FFFF_FFF8);
    cycle("v_u",    1'b1, 32'h123450B7, 1'b0, 1'b1);
    chk("v_u.noU", {61'b0, b3.formato}, 64'd7);
    cycle("v_j",    1'b1, 32'h0010006F, 1'b0, 1'b1);
    cycle("v_sh1",  1'b1, 32'h01F09093, 1'b0, 1'b1);
    cycle("v_sh2",  1'b1, 32'h4030D093, 1'b0, 1'b1);
    cycle("v_ill",  1'b1, 32'h0000007F, 1'b0, 1'b1);
    cycle("v_r",    1'b1, 32'h00B50533, 1'b0, 1'b1);
    cycle("v_idle", 1'b0, 32'h0,        1'b0, 1'b1);
    cycle("v_idle", 1'b0, 32'h0,        1'b0, 1'b1);

    // Back-pressure: three offers while the consumer stalls, then release.
    cycle("stall0", 1'b1, 32'hFFF00093, 1'b0, 1'b0);
    cycle("stall1", 1'b1, 32'h0010006F, 1'b0, 1'b0);
    chk("stall.full_s2", 64'(b1.in_ready), 64'd0);
    cycle("stall2", 1'b1, 32'h123450B7, 1'b0, 1'b0);
    cycle("release", 1'b1, 32'h123450B7, 1'b0, 1'b1);
    cycle("drain0", 1'b0, 32'h0, 1'b0, 1'b1);
    cycle("drain1", 1'b0, 32'h0, 1'b0, 1'b1);
    cycle("drain2", 1'b0, 32'h0, 1'b0, 1'b1);

    // Flush while full with a concurrent input offer.
    cycle("fill0", 1'b1, 32'hFE112E23, 1'b0, 1'b0);
    cycle("fill1", 1'b1, 32'hFE000CE3, 1'b0, 1'b0);
    cycle("flush", 1'b1, 32'h01F09093, 1'b1, 1'b1);
    chk("flush.after_s2", 64'(b1.out_valid), 64'd0);
    cycle("post0", 1'b0, 32'h0, 1'b0, 1'b1);
    cycle("post1", 1'b0, 32'h0, 1'b0, 1'b1);

    // Randomised traffic with bubbles, stalls and occasional flushes.
    for (int n = 0; n < 400; n++)
      cycle("rand", ($urandom_range(0, 3) != 0), rand_instr(),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0));

    // Reset asserted between edges while the pipe holds data.
    cycle("pre_rst0", 1'b1, 32'hFFF00093, 1'b0, 1'b0);
    drive_and_check("pre_rst1", 1'b1, 32'h0010006F, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_all("rst_async");
    chk("rst_async.s2_valid", 64'(b1.out_valid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    cycle("after_rst0", 1'b1, 32'hFE000CE3, 1'b0, 1'b1);
    cycle("after_rst1", 1'b0, 32'h0, 1'b0, 1'b1);
    cycle("after_rst2", 1'b0, 32'h0, 1'b0, 1'b1);

    for (int n = 0; n < 200; n++)
      cycle("rand2", ($urandom_range(0, 3) != 0), rand_instr(),
            ($urandom_range(0, 30) == 0), ($urandom_range(0, 3) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
